uart_rx_param: RTL and testbench

Parametrised UART receiver: the next generation of the fixed 8N1 receiver in the softmax-approximation host link. It accepts 5–9 data bits, an optional parity bit, and 1 or 2 stop bits. Each bit is decided by majority-of-3 voting at mid-bit, and framing and parity errors are reported alongside each received word. It sits between the board RX pin and the command/data deserialiser that feeds the approximation tree.

---
 rtl/uart_rx_param.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with 5-9 data bits, 1-2 stop bits, and majority-of-3 voting at mid-bit.
// The optional parity bit is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 391,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rxd,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rxd,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int H     = (CLKS_PER_BIT - 1) >> 1;

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_param: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_s;
    logic [1:0]            r_hist;
    logic                  r_vote;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_ferr;
    logic                  w_half;
    logic                  w_full;
    logic                  w_last_data;
    logic                  w_last_stop;
`ifdef UART_RX_PARITY_EN
    logic                  r_perr;
`endif

    assign w_s         = r_sync2;
    assign w_half      = (r_cnt == CNT_W'(H));
    assign w_full      = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_data = (r_bit == BIT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit == BIT_W'(STOP_BITS - 1));

    // The newest sample w_s is the third history entry, so the vote includes it the cycle it arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 2'b11;
            r_vote  <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[0], w_s};
            r_vote  <= (r_hist[1] & r_hist[0]) | (r_hist[1] & w_s) | (r_hist[0] & w_s);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (!w_s) w_state_nxt = S_START;
            S_START:  if (w_half) w_state_nxt = r_vote ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_full && w_last_data) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_full) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_full && w_last_stop) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered on the last stop sample so they become visible during the DONE cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_ferr       <= 1'b0;
            o_rx_valid   <= 1'b0;
            o_rxd        <= '0;
            o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr       <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_rx_valid <= 1'b0;
            case (r_state)
                S_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                S_DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_shift <= {r_vote, r_shift[DATA_BITS-1:1]};
                        r_bit   <= w_last_data ? '0 : r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_full) begin
                        r_cnt  <= '0;
                        r_perr <= ((^r_shift) ^ r_vote) != (PARITY_ODD != 0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_full) begin
                        r_cnt  <= '0;
                        r_bit  <= r_bit + 1'b1;
                        r_ferr <= r_ferr | ~r_vote;
                        if (w_last_stop) begin
                            o_rx_valid   <= 1'b1;
                            o_rxd        <= r_shift;
                            o_frame_err  <= r_ferr | ~r_vote;
`ifdef UART_RX_PARITY_EN
                            o_parity_err <= r_perr;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_bit  <= '0;
                    r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    r_perr <= 1'b0;
`endif
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8-data/1-stop and a 7-data/2-stop receiver at 16 clocks per bit,
// each checked against a frame-level scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam bit PE = (P == 1);
    localparam int NA = 8 + P + 1;

    typedef struct {
        bit         sel;      // 0: 8-data/1-stop line, 1: 7-data/2-stop line
        logic [8:0] word;
        bit         pflip;    // send the wrong parity bit
        logic [1:0] stops;    // stop bit values on the wire, first in bit 0
        bit         spike;    // one-cycle inverted spike inside data bit 2
        int         gap;      // idle cycles before the start bit
        logic [8:0] ew;
        bit         ef;
        bit         ep;
    } vec_t;

    typedef struct {
        logic [8:0]  word;
        bit          ferr;
        bit          perr;
        int unsigned t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       va, fa, pa, ba;
    logic       vb, fb, pb, bb;
    logic [7:0] wa;
    logic [6:0] wb;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned nva = 0, nvb = 0, npa = 0, npb = 0;
    logic        pva = 1'b0, pvb = 1'b0;
    exp_t        qa[$];
    exp_t        qb[$];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd_a), .o_rx_valid(va), .o_rxd(wa),
        .o_frame_err(fa), .o_parity_err(pa), .o_busy(ba));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd_b), .o_rx_valid(vb), .o_rxd(wb),
        .o_frame_err(fb), .o_parity_err(pb), .o_busy(bb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic on_valid(input bit sel, input logic [8:0] w, input bit f, input bit pe);
        exp_t e;
        int   n;
        n = sel ? qb.size() : qa.size();
        chk(sel ? "b_valid_expected" : "a_valid_expected", (n > 0), 1);
        if (n > 0) begin
            e = sel ? qb.pop_front() : qa.pop_front();
            chk(sel ? "b_word" : "a_word", w, e.word);
            chk(sel ? "b_frame_err" : "a_frame_err", f, e.ferr);
            chk(sel ? "b_parity_err" : "a_parity_err", pe, e.perr);
            chk(sel ? "b_latency" : "a_latency", cyc, e.t);
        end
    endtask

    always @(negedge clk) begin
        if (va) begin
            nva++;
            chk("a_valid_single_cycle", pva, 0);
            on_valid(1'b0, {1'b0, wa}, fa, pa);
        end
        if (vb) begin
            nvb++;
            chk("b_valid_single_cycle", pvb, 0);
            on_valid(1'b1, {2'b00, wb}, fb, pb);
        end
        pva <= va;
        pvb <= vb;
    end

    task automatic put(input bit sel, input logic v, input int n);
        if (sel) rxd_b = v; else rxd_a = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Frame-level reference: what the receiver must report for the bits placed on the wire.
    function automatic vec_t model(input vec_t v);
        vec_t       r;
        logic [8:0] d;
        logic       pbit;
        int         nd;
        r  = v;
        d  = '0;
        nd = v.sel ? 7 : 8;
        for (int k = 0; k < nd; k++) d[k] = v.word[k];
        r.ew = d;
        r.ef = v.sel ? (v.stops != 2'b11) : !v.stops[0];
        pbit = (^d) ^ v.pflip;
        r.ep = PE && (((^d) ^ pbit) != 1'b0);
        return r;
    endfunction

    task automatic send(input vec_t v);
        exp_t e;
        int   nd, ns;
        logic par;
        nd = v.sel ? 7 : 8;
        ns = v.sel ? 2 : 1;
        repeat (v.gap) begin @(posedge clk); #1; end
        e.word = v.ew;
        e.ferr = v.ef;
        e.perr = v.ep;
        e.t    = cyc + 4 + H + (nd + P + ns) * CPB;
        if (v.sel) begin qb.push_back(e); npb++; end
        else       begin qa.push_back(e); npa++; end
        put(v.sel, 1'b0, CPB);
        par = 1'b0;
        for (int k = 0; k < nd; k++) begin
            par = par ^ v.word[k];
            if (v.spike && k == 2) begin
                // offset 6 lands inside the three samples voted on for this bit
                put(v.sel, v.word[k], 6);
                put(v.sel, ~v.word[k], 1);
                put(v.sel, v.word[k], CPB - 7);
            end else begin
                put(v.sel, v.word[k], CPB);
            end
        end
        if (P == 1) put(v.sel, par ^ v.pflip, CPB);
        for (int s = 0; s < ns; s++) put(v.sel, v.stops[s], CPB);
        if (!v.stops[ns-1]) put(v.sel, 1'b1, CPB);
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        while ((qa.size() + qb.size()) != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk("drain_pending_frames", qa.size() + qb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab[9];
        vec_t        v;
        logic [8:0]  wv;
        int unsigned p;

        tab[0] = '{0, 9'h0A5, 0, 2'b11, 0, 0, 9'h0A5, 0, 0};
        tab[1] = '{0, 9'h03C, 0, 2'b11, 1, 5, 9'h03C, 0, 0};
        tab[2] = '{1, 9'h055, 0, 2'b01, 0, 0, 9'h055, 1, 0};
        tab[3] = '{0, 9'h00F, 0, 2'b11, 0, 3, 9'h00F, 0, 0};
        tab[4] = '{0, 9'h00F, 1, 2'b11, 0, 0, 9'h00F, 0, PE};
        tab[5] = '{0, 9'h000, 0, 2'b11, 0, 0, 9'h000, 0, 0};
        tab[6] = '{0, 9'h0FF, 0, 2'b11, 0, 0, 9'h0FF, 0, 0};
        tab[7] = '{0, 9'h081, 0, 2'b11, 0, 0, 9'h081, 0, 0};
        tab[8] = '{1, 9'h02A, 0, 2'b10, 0, 0, 9'h02A, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", va, 0); chk("rst_a_rxd", wa, 0); chk("rst_a_ferr", fa, 0);
        chk("rst_a_perr", pa, 0);  chk("rst_a_busy", ba, 0);
        chk("rst_b_valid", vb, 0); chk("rst_b_rxd", wb, 0); chk("rst_b_ferr", fb, 0);
        chk("rst_b_perr", pb, 0);  chk("rst_b_busy", bb, 0);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_a_busy", ba, 0);
        chk("idle_b_busy", bb, 0);

        for (int i = 0; i < 9; i++) send(tab[i]);
        drain();

        // 4-cycle low glitch: START is entered, then rejected at the mid-bit check
        p = cyc;
        rxd_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_rises", ba, 1);
        @(posedge clk); #1;
        chk("glitch_edge_count", cyc - p, 4);
        rxd_a = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_clears", ba, 0);
        @(posedge clk); #1;
        repeat (2 * CPB) begin @(posedge clk); #1; end

        for (int i = 0; i < 40; i++) begin
            v.sel   = 1'($urandom % 2);
            v.word  = 9'($urandom);
            v.pflip = ($urandom % 4) == 0;
            v.stops = (($urandom % 5) == 0) ? 2'($urandom) : 2'b11;
            v.spike = 1'b0;
            v.gap   = int'($urandom % 20);
            send(model(v));
        end
        drain();

        // break: line held low yields word 0 with a framing error, then re-arms on the low line
        p = cyc;
        v = model('{0, 9'h000, 0, 2'b00, 0, 0, 9'h000, 0, 0});
        qa.push_back('{v.ew, v.ef, v.ep, p + 4 + H + NA * CPB});
        npa++;
        rxd_a = 1'b0;
        repeat (4 + H + NA * CPB + 1) @(posedge clk);
        #1;
        rxd_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("break_rearm_busy", ba, 1);
        @(posedge clk); #1;
        repeat (2 * CPB) begin @(posedge clk); #1; end
        chk("break_rearm_rejected", ba, 0);
        drain();

        // reset during data bit 4: no partial word, outputs back at reset values at once
        wv = 9'h096;
        put(0, 1'b0, CPB);
        for (int k = 0; k < 4; k++) put(0, wv[k], CPB);
        put(0, wv[4], 2);
        rst = 1'b1;
        #1;
        chk("midrst_valid", va, 0); chk("midrst_rxd", wa, 0); chk("midrst_ferr", fa, 0);
        chk("midrst_perr", pa, 0);  chk("midrst_busy", ba, 0);
        rxd_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        put(0, 1'b1, CPB);
        send(model('{0, 9'h096, 0, 2'b11, 0, 0, 9'h000, 0, 0}));
        drain();

        chk("a_valid_count", nva, npa);
        chk("b_valid_count", nvb, npb);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
